blink_pattern_seq: RTL and testbench
====================================

BLINK_PATTERN_SEQ -- requirements
Module: blink_pattern_seq

Interface
REQ-001 Parameter N_LEDS, default 4: number of LED outputs driven.
REQ-002 Parameter STEPS, default 8, power of two, at least 2: pattern steps per sequence.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 tick  input  1  one-cycle step-advance pulse from the upstream blink counter wrap flag.
REQ-006 en  input  1  sequencer enable, level-sensitive.
REQ-007 pat_valid  input  1  new pattern offered.
REQ-008 pat_data  input  N_LEDS*STEPS  pattern; step k occupies bits [k*N_LEDS +: N_LEDS].
REQ-009 pat_ready  output  1  block can accept a pattern this cycle.
REQ-010 leds  output  N_LEDS  registered LED drive.
REQ-011 step  output  log2(STEPS)  current step index.
REQ-012 wrap  output  1  one-cycle pulse when the step index returns from STEPS-1 to 0.
REQ-013 busy  output  1  high while the state is RUN.

Function
REQ-014 The block SHALL implement exactly three states: IDLE, ARMED and RUN.
- IDLE: no valid active pattern.
- ARMED: active pattern valid, en low.
- RUN: sequencing.
REQ-015 A pattern transfer SHALL occur on a cycle where pat_valid and pat_ready are both high; pat_data is sampled on that edge.
REQ-016 The block SHALL hold one active pattern register and one shadow register with a shadow_full flag.
REQ-017 pat_ready SHALL equal !shadow_full.
REQ-018 In IDLE or ARMED, a transfer SHALL load the active register directly; the state then goes to ARMED, or to RUN if en is high.
REQ-019 In RUN, a transfer SHALL load the shadow register and set shadow_full.
REQ-020 ARMED SHALL go to RUN on the first cycle en is high; RUN SHALL go to ARMED on the first cycle en is low.
REQ-021 Leaving RUN SHALL force step to 0 and leds to 0; the active pattern is retained.
REQ-022 In RUN, a cycle with tick high SHALL increment step modulo STEPS; step changes on the edge after the tick cycle (latency 1).
REQ-023 tick SHALL be ignored outside RUN.
REQ-024 When step == STEPS-1 and tick is high in RUN, step SHALL become 0 and wrap SHALL be high for exactly the next cycle.
REQ-025 On that wrap edge, if shadow_full is set, the shadow SHALL be copied to active and shadow_full cleared.
REQ-026 If a transfer coincides with a wrap edge while shadow_full is clear, pat_data SHALL load the active register directly, bypassing the shadow.
REQ-027 In RUN, leds SHALL equal the active-pattern slice for the current step value, updated one cycle after step changes (registered).
REQ-028 pat_valid held high with pat_ready low SHALL have no effect; the upstream holds the data.
REQ-029 busy SHALL be high exactly when the state is RUN.

Reset
REQ-030 While rst is high: state IDLE; step 0; leds 0; wrap 0; shadow_full 0; active and shadow registers 0.
REQ-031 pat_ready SHALL be 1 after reset.
REQ-032 Reset asserted mid-RUN SHALL discard both patterns immediately, without waiting for a clock edge.

Structure
REQ-033 The state enumeration and the default values of N_LEDS and STEPS SHALL live in a shared package, blink_pkg.
REQ-034 The step counter with its wrap-pulse generation SHALL be a sub-module, blink_step_ctr, parameterised by STEPS.
REQ-035 All other logic SHALL stay in blink_pattern_seq; no latches and no combinational outputs except pat_ready.

Verification
REQ-036 Reset, then load 0xF0F0_F0F0 with en=1, then apply 8 ticks: step runs 0..7,0; wrap pulses once; leds alternate 0x0 and 0xF.
REQ-037 Load a second pattern while in RUN at step 3: pat_ready drops to 0; leds are unchanged until the wrap; the new pattern appears at step 0; pat_ready returns to 1.
REQ-038 Offer a third pattern while shadow_full is set: pat_ready stays 0 and no transfer occurs; the pattern is accepted the cycle after the wrap.
REQ-039 With shadow empty, a transfer on the same edge as a tick at step 7: the new pattern takes effect at step 0 and shadow_full stays 0.
REQ-040 Drop en at step 5, then raise it again: busy falls; step and leds go to 0; RUN resumes from step 0 with the same pattern.
REQ-041 Assert rst asynchronously mid-RUN: all outputs go to 0 without a clock edge; after release, tick has no effect until a new pattern is loaded.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared definitions for the blink pattern sequencer: state encoding and
// default geometry (LED count and steps per sequence).
package blink_pkg;

  localparam int N_LEDS_DEF = 4;
  localparam int STEPS_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } blink_state_e;

endpackage

// File: rtl/blink_step_ctr.sv
// Step index counter for the blink sequencer. Advances on adv_i, returns to
// zero on clr_i, and emits a one-cycle wrap pulse when it rolls over from
// the last step back to zero.
module blink_step_ctr #(
  parameter int STEPS = blink_pkg::STEPS_DEF,
  parameter int SW    = $clog2(STEPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [SW-1:0] step_o,
  output logic          wrap_o
);

  localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

  logic [SW-1:0] step_q, step_d;
  logic          wrap_q, wrap_d;

  // Next step value; clear has priority so leaving RUN always lands on step 0.
  always_comb begin
    step_d = step_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      step_d = '0;
    end else if (adv_i) begin
      step_d = (step_q == LAST) ? '0 : step_q + SW'(1);
      wrap_d = (step_q == LAST);
    end
  end

  // Step and wrap registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign step_o = step_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/blink_pattern_seq.sv
// Blink pattern sequencer: holds an active LED pattern plus one shadow slot,
// steps through the pattern on upstream ticks and swaps in the shadow pattern
// at the end of each full sequence so a pattern is never torn mid-sequence.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | no valid active pattern
// ST_ARMED | active pattern valid, sequencing held off (en low)
// ST_RUN   | sequencing the active pattern on tick
module blink_pattern_seq
  import blink_pkg::*;
#(
  parameter int N_LEDS = N_LEDS_DEF,
  parameter int STEPS  = STEPS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       en,
  input  logic                       pat_valid,
  input  logic [N_LEDS*STEPS-1:0]    pat_data,
  output logic                       pat_ready,
  output logic [N_LEDS-1:0]          leds,
  output logic [$clog2(STEPS)-1:0]   step,
  output logic                       wrap,
  output logic                       busy
);

  localparam int            SW   = $clog2(STEPS);
  localparam int            PW   = N_LEDS * STEPS;
  localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

  blink_state_e      state_q, state_d;
  logic [PW-1:0]     active_q, active_d;
  logic [PW-1:0]     shadow_q, shadow_d;
  logic              shadow_full_q, shadow_full_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic              busy_q, busy_d;
  logic [N_LEDS-1:0] slice;
  logic              xfer;
  logic              run_stay;
  logic              wrap_edge;

  assign pat_ready = !shadow_full_q;
  assign xfer      = pat_valid && !shadow_full_q;
  // Only a cycle that stays in RUN may advance; dropping en clears the step.
  assign run_stay  = (state_q == ST_RUN) && en;
  assign wrap_edge = run_stay && tick && (step == LAST);

  blink_step_ctr #(
    .STEPS (STEPS)
  ) u_step_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!run_stay),
    .adv_i  (tick),
    .step_o (step),
    .wrap_o (wrap)
  );

  // Select the active-pattern slice for the current step.
  always_comb begin
    slice = '0;
    for (int k = 0; k < STEPS; k++) begin
      if (step == SW'(k)) slice = active_q[k*N_LEDS +: N_LEDS];
    end
  end

  // Next-state and pattern-register update logic.
  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    leds_d        = run_stay ? slice : '0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          active_d = pat_data;
          state_d  = en ? ST_RUN : ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (xfer) active_d = pat_data;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en) state_d = ST_ARMED;
        if (wrap_edge) begin
          // Sequence boundary: promote the shadow, or take a coincident
          // transfer straight into active when nothing is waiting.
          if (shadow_full_q) begin
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
          end else if (xfer) begin
            active_d = pat_data;
          end
        end else if (xfer) begin
          shadow_d      = pat_data;
          shadow_full_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // State register; busy is registered alongside it so it tracks RUN exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // Pattern registers and LED drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q      <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      leds_q        <= '0;
    end else begin
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      leds_q        <= leds_d;
    end
  end

  assign leds = leds_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_blink_pattern_seq.sv
// Bench for blink_pattern_seq: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_blink_pattern_seq;

  localparam int N  = 4;
  localparam int S  = 8;
  localparam int PW = N * S;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick, en, pat_valid;
  logic [PW-1:0] pat_data;
  logic          pat_ready;
  logic [N-1:0]  leds;
  logic [2:0]    step;
  logic          wrap, busy;

  int total = 0;
  int bad   = 0;

  blink_pattern_seq #(.N_LEDS(N), .STEPS(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .en        (en),
    .pat_valid (pat_valid),
    .pat_data  (pat_data),
    .pat_ready (pat_ready),
    .leds      (leds),
    .step      (step),
    .wrap      (wrap),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: running flag, loaded flag, pending queue (depth 1).
  logic [PW-1:0] m_active = '0;
  logic [PW-1:0] m_pend[$];
  bit            m_loaded = 0;
  bit            m_run    = 0;
  int            m_step   = 0;
  bit            m_wrap   = 0;
  int            m_leds   = 0;
  bit            go, mx, mw;
  logic [PW-1:0] sh;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_active = '0; m_pend.delete(); m_loaded = 0; m_run = 0;
      m_step = 0; m_wrap = 0; m_leds = 0;
    end else begin
      go = m_run && en;
      mx = pat_valid && (m_pend.size() == 0);
      mw = go && tick && (m_step == S - 1);
      sh = m_active >> (m_step * N);
      m_leds = go ? int'(sh[N-1:0]) : 0;
      m_wrap = mw;
      m_step = go ? (tick ? (m_step + 1) % S : m_step) : 0;
      if (!m_run) begin
        if (mx) begin m_active = pat_data; m_loaded = 1; end
        m_run = m_loaded && en;
      end else begin
        if (mw) begin
          if (m_pend.size() != 0) m_active = m_pend.pop_front();
          else if (mx) m_active = pat_data;
        end else if (mx) begin
          m_pend.push_back(pat_data);
        end
        m_run = en;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("step", int'(step), m_step);
      chk("wrap", int'(wrap), int'(m_wrap));
      chk("leds", int'(leds), m_leds);
      chk("busy", int'(busy), int'(m_run));
      chk("ready", int'(pat_ready), int'(m_pend.size() == 0));
    end
  end

  task automatic cyc(input bit t, input bit e, input bit v, input logic [PW-1:0] d);
    tick = t; en = e; pat_valid = v; pat_data = d;
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1;
    chk("rst_leds", int'(leds), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(pat_ready), 1);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  int wraps;

  initial begin
    rst = 1'b1; tick = 0; en = 0; pat_valid = 0; pat_data = '0;
    repeat (3) @(negedge clk);
    chk("init_leds", int'(leds), 0);
    chk("init_step", int'(step), 0);
    chk("init_busy", int'(busy), 0);
    chk("init_ready", int'(pat_ready), 1);
    rst = 1'b0;

    // Load with en high, then a full sequence of ticks.
    cyc(0, 1, 1, 32'hF0F0_F0F0);
    chk("load_busy", int'(busy), 1);
    cyc(0, 1, 0, '0);
    wraps = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 1, 0, '0);
      wraps += int'(wrap);
      chk("seq_step", int'(step), k % 8);
      chk("seq_leds", int'(leds), ((k - 1) % 2 == 1) ? 15 : 0);
    end
    chk("seq_wraps", wraps, 1);
    cyc(0, 1, 0, '0);
    chk("post_wrap", int'(wrap), 0);

    // Second pattern offered at step 3 goes to the shadow until the wrap.
    repeat (3) cyc(1, 1, 0, '0);
    chk("at_step3", int'(step), 3);
    cyc(0, 1, 1, 32'h1234_5678);
    chk("shadow_ready", int'(pat_ready), 0);
    repeat (5) cyc(1, 1, 0, '0);
    cyc(0, 1, 0, '0);
    chk("p2_leds", int'(leds), 8);
    chk("p2_ready", int'(pat_ready), 1);

    // Third pattern held while the shadow is full; accepted after the wrap.
    cyc(0, 1, 1, 32'hA5A5_3C3C);
    repeat (8) cyc(1, 1, 1, 32'h0F1E_2D3C);
    chk("held_ready", int'(pat_ready), 1);
    cyc(0, 1, 1, 32'h0F1E_2D3C);
    chk("held_taken", int'(pat_ready), 0);
    cyc(0, 1, 0, '0);
    repeat (8) cyc(1, 1, 0, '0);

    // Transfer coinciding with the wrap edge bypasses the empty shadow.
    repeat (7) cyc(1, 1, 0, '0);
    cyc(1, 1, 1, 32'h7654_321F);
    chk("bypass_ready", int'(pat_ready), 1);
    chk("bypass_wrap", int'(wrap), 1);
    cyc(0, 1, 0, '0);
    chk("bypass_leds", int'(leds), 15);

    // Drop en at step 5 then resume.
    repeat (5) cyc(1, 1, 0, '0);
    cyc(0, 0, 0, '0);
    chk("pause_busy", int'(busy), 0);
    chk("pause_step", int'(step), 0);
    chk("pause_leds", int'(leds), 0);
    cyc(0, 1, 0, '0);
    chk("resume_busy", int'(busy), 1);
    cyc(0, 1, 0, '0);
    chk("resume_leds", int'(leds), 15);

    // Asynchronous reset mid-RUN; ticks then do nothing until a new load.
    repeat (3) cyc(1, 1, 0, '0);
    cyc(0, 1, 0, '0);
    pulse_rst();
    repeat (3) cyc(1, 1, 0, '0);
    chk("after_rst_step", int'(step), 0);
    chk("after_rst_busy", int'(busy), 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) pulse_rst();
      else cyc($urandom_range(0, 1) == 1, $urandom_range(0, 9) != 0,
               $urandom_range(0, 9) < 3, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
